layer3_window_gen: RTL and testbench

LAYER3_WINDOW_GEN -- requirements
Module: layer3_window_gen

---
 rtl/layer3_window_gen.sv | 128 ++++++++++++
 tb/tb_layer3_window_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/layer3_window_gen.sv
// rtl/layer3_window_gen.sv - 3x3 sliding-window generator over a raster pixel stream with external row delays
module layer3_window_gen #(
  parameter int DATA_W = 128,
  parameter int IMG_W  = 15,
  parameter int IMG_H  = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic [DATA_W-1:0]     dly0_o,
  output logic [DATA_W-1:0]     dly1_o,
  input  logic [DATA_W-1:0]     dly0_i,
  input  logic [DATA_W-1:0]     dly1_i,
  output logic [9*DATA_W-1:0]   win_data,
  output logic                  win_valid,
  output logic                  frame_done,
  output logic                  err
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  logic              last_px;
  logic              gap;

  // tap[0] = oldest line (from delay stage 1), tap[2] = current line; index 0 newest column
  logic [DATA_W-1:0] tap [3][3];

  assign last_px = (row_cnt == RW'(IMG_H - 1)) && (col_cnt == CW'(IMG_W - 1));
  assign gap     = (state == RUN) && !in_valid;

  // Tap rows shift every cycle so they stay aligned with the free-running delay stages
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int j = 0; j < 3; j++) begin
          tap[r][j] <= '0;
        end
      end
    end else begin
      tap[2][0] <= in_data;
      tap[1][0] <= dly0_i;
      tap[0][0] <= dly1_i;
      for (int r = 0; r < 3; r++) begin
        for (int j = 1; j < 3; j++) begin
          tap[r][j] <= tap[r][j-1];
        end
      end
    end
  end

  assign dly0_o = tap[2][2];
  assign dly1_o = tap[1][2];

  // Element k = 3*row + col; col 0 is the oldest column, held in the last tap of the row
  for (genvar k = 0; k < 9; k++) begin : g_win
    assign win_data[k*DATA_W +: DATA_W] = tap[k/3][2-(k%3)];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: any accepted pixel keeps the frame running (counters are 0 in IDLE/DONE,
  // so that pixel is (0,0)); a missing pixel always returns to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN, DONE: begin
        if (in_valid) begin
          state_nxt = last_px ? DONE : RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Position of the next pixel to be accepted; cleared whenever the stream is idle or breaks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (!in_valid) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (col_cnt == CW'(IMG_W - 1)) begin
      col_cnt <= '0;
      row_cnt <= (row_cnt == RW'(IMG_H - 1)) ? '0 : row_cnt + 1'b1;
    end else begin
      col_cnt <= col_cnt + 1'b1;
    end
  end

  // Window is complete once the accepted pixel is at least two rows and two columns in
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_valid <= 1'b0;
    end else begin
      win_valid <= in_valid && (row_cnt >= RW'(2)) && (col_cnt >= CW'(2));
    end
  end

  // Sticky gap error; does not stall later frames
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (gap) begin
      err <= 1'b1;
    end
  end

  assign frame_done = (state == DONE);

endmodule

// File: tb/tb_layer3_window_gen.sv
// tb/tb_layer3_window_gen.sv - scoreboard bench for layer3_window_gen
module tb_layer3_window_gen;

  localparam int DW  = 128;
  localparam int IW  = 15;
  localparam int IH  = 15;
  localparam int DLY = IW - 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DW-1:0]     in_data;
  logic [DW-1:0]     dly0_o, dly1_o, dly0_i, dly1_i;
  logic [9*DW-1:0]   win_data;
  logic              win_valid, frame_done, err;

  layer3_window_gen #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .dly0_o(dly0_o), .dly1_o(dly1_o), .dly0_i(dly0_i), .dly1_i(dly1_i),
    .win_data(win_data), .win_valid(win_valid), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  // external row-delay stages, free running, no reset
  logic [DW-1:0] d0 [DLY];
  logic [DW-1:0] d1 [DLY];
  always @(posedge clk) begin
    d0[0] <= dly0_o;
    d1[0] <= dly1_o;
    for (int i = 1; i < DLY; i++) begin
      d0[i] <= d0[i-1];
      d1[i] <= d1[i-1];
    end
  end
  assign dly0_i = d0[DLY-1];
  assign dly1_i = d1[DLY-1];

  typedef struct {
    logic [9*DW-1:0] data;
    logic            last;
  } exp_t;

  exp_t exp_q[$];
  int   fd_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   win_cnt = 0;
  int   fd_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int tag, input int r, input int c);
    logic [DW-1:0] v;
    v = '0;
    v[7:0]   = 8'(r * 16 + c);
    v[23:16] = 8'(tag);
    return v;
  endfunction

  function automatic logic [9*DW-1:0] exp_win(input int tag, input int r, input int c);
    logic [9*DW-1:0] w;
    for (int k = 0; k < 9; k++) begin
      w[k*DW +: DW] = pix(tag, r - 2 + k / 3, c - 2 + k % 3);
    end
    return w;
  endfunction

  // monitor: pop an expected window for every win_valid
  always @(negedge clk) begin
    if (win_valid) begin
      win_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window: win_valid=1 at cycle %0d with no window expected", cyc);
      end else begin
        exp_t e;
        int bad;
        e = exp_q.pop_front();
        bad = -1;
        for (int k = 8; k >= 0; k--) begin
          if (win_data[k*DW +: DW] !== e.data[k*DW +: DW]) bad = k;
        end
        if (bad >= 0) begin
          errors++;
          $display("FAIL win_data: element %0d got %0h expected %0h", bad,
                   win_data[bad*DW +: 32], e.data[bad*DW +: 32]);
        end
        chk("frame_done_with_window", {63'd0, frame_done}, {63'd0, e.last});
      end
    end else if (frame_done) begin
      checks++;
      errors++;
      $display("FAIL frame_done_alone: got 1 expected 0 at cycle %0d", cyc);
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc.push_back(cyc);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = '1;
    end
  endtask

  // drive the first n pixels of a frame in raster order, queueing expected windows
  task automatic drive_frame(input int tag, input int n);
    for (int p = 0; p < n; p++) begin
      int r, c;
      exp_t e;
      r = p / IW;
      c = p % IW;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = pix(tag, r, c);
      if (r >= 2 && c >= 2) begin
        e.data = exp_win(tag, r, c);
        e.last = (r == IH - 1) && (c == IW - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_win_valid"}, {63'd0, win_valid}, 64'd0);
    chk({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_win_data_nonzero"}, {63'd0, |win_data}, 64'd0);
    chk({tag, "_dly_nonzero"}, {63'd0, |{dly0_o, dly1_o}}, 64'd0);
  endtask

  int w0, f0;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b1;

    // single full frame
    w0 = win_cnt; f0 = fd_cnt;
    drive_frame(0, IW * IH);
    idle(4);
    chk("frame1_windows", 64'(win_cnt - w0), 64'd169);
    chk("frame1_done_pulses", 64'(fd_cnt - f0), 64'd1);
    chk("frame1_err", {63'd0, err}, 64'd0);

    // two frames back to back
    w0 = win_cnt; f0 = fd_cnt;
    drive_frame(1, IW * IH);
    drive_frame(2, IW * IH);
    idle(4);
    chk("b2b_windows", 64'(win_cnt - w0), 64'd338);
    chk("b2b_done_pulses", 64'(fd_cnt - f0), 64'd2);
    if (fd_cyc.size() >= 2)
      chk("b2b_done_spacing", 64'(fd_cyc[fd_cyc.size()-1] - fd_cyc[fd_cyc.size()-2]), 64'd225);
    chk("b2b_err", {63'd0, err}, 64'd0);

    // gap at pixel (5,7)
    drive_frame(3, 5 * IW + 7);
    idle(1);
    chk("gap_err_before", {63'd0, err}, 64'd0);
    @(posedge clk);
    #1;
    chk("gap_err_next_cycle", {63'd0, err}, 64'd1);
    idle(3);
    w0 = win_cnt; f0 = fd_cnt;
    drive_frame(4, IW * IH);
    idle(4);
    chk("after_gap_windows", 64'(win_cnt - w0), 64'd169);
    chk("after_gap_done_pulses", 64'(fd_cnt - f0), 64'd1);
    chk("err_sticky", {63'd0, err}, 64'd1);

    // reset during row 8
    drive_frame(5, 8 * IW + 2);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    chk("midreset_queue_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    w0 = win_cnt; f0 = fd_cnt;
    drive_frame(6, IW * IH);
    idle(4);
    chk("after_reset_windows", 64'(win_cnt - w0), 64'd169);
    chk("after_reset_done_pulses", 64'(fd_cnt - f0), 64'd1);
    chk("after_reset_err", {63'd0, err}, 64'd0);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
